// File: rtl/dec_countdown_arb_if.sv
// dec_countdown_arb_if: request/grant/done bundle between two requesters and the countdown scheduler
interface dec_countdown_arb_if #(parameter int WIDTH = 64);
  logic             Req0;
  logic [WIDTH-1:0] Val0;
  logic             Req1;
  logic [WIDTH-1:0] Val1;
  logic             Gnt0;
  logic             Gnt1;
  logic             Done0;
  logic             Done1;
  logic             Busy;
  logic [WIDTH-1:0] Count;
  modport master (output Req0, Val0, Req1, Val1, input Gnt0, Gnt1, Done0, Done1, Busy, Count);
  modport slave  (input Req0, Val0, Req1, Val1, output Gnt0, Gnt1, Done0, Done1, Busy, Count);
endinterface

// File: rtl/dec_countdown_arb.sv
// dec_countdown_arb: round-robin two-requester countdown scheduler sharing one decrementer
module dec_countdown_arb #(parameter int WIDTH = 64) (
  input logic Clk,
  input logic Rst,
  dec_countdown_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, dec;
  logic [1:0] gnt_q, gnt_d, done_q, done_d;
  logic owner_q, owner_d, last_q, last_d;
  logic grant, sel, zero;
  assign dec   = count_q - WIDTH'(1);
  assign zero  = count_q == '0;
  assign grant = state_q == IDLE && (bus.Req0 || bus.Req1);
  // on contention serve whoever was not granted last
  assign sel   = (bus.Req0 && bus.Req1) ? ~last_q : bus.Req1;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      count_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (grant ? RUN : IDLE)
            : state_q == RUN  ? (zero ? DONE : RUN)
            : IDLE;
  end
  always_comb begin
    count_d = grant ? (sel ? bus.Val1 : bus.Val0)
            : (state_q == RUN && !zero) ? dec
            : count_q;
    owner_d = grant ? sel : owner_q;
    last_d  = grant ? sel : last_q;
    gnt_d   = {grant && sel, grant && !sel};
    done_d  = (state_q == RUN && zero) ? {owner_q, ~owner_q} : 2'b00;
  end
  assign bus.Gnt0  = gnt_q[0];
  assign bus.Gnt1  = gnt_q[1];
  assign bus.Done0 = done_q[0];
  assign bus.Done1 = done_q[1];
  assign bus.Busy  = state_q != IDLE;
  assign bus.Count = count_q;
endmodule

// File: tb/tb_dec_countdown_arb.sv
// tb_dec_countdown_arb: directed checks of grant order, countdown timing, reset and full range at WIDTH=8
module tb_dec_countdown_arb;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int checks = 0;
  int errors = 0;
  dec_countdown_arb_if #(.WIDTH(8)) bus();
  dec_countdown_arb #(.WIDTH(8)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] obs();
    return {bus.Gnt1, bus.Gnt0, bus.Done1, bus.Done0, bus.Busy, bus.Count};
  endfunction

  function automatic logic [12:0] ex(input logic g1, g0, d1, d0, b, input logic [7:0] c);
    return {g1, g0, d1, d0, b, c};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  int gk[$];
  int gid[$];
  int viol, bad;

  initial begin
    bus.Req0 = 1'b1; bus.Val0 = 8'd3; bus.Req1 = 1'b0; bus.Val1 = 8'd0;
    // reset held two cycles with Req0 high
    step(); chk("rst_e1", obs(), ex(0,0,0,0,0,8'd0));
    step(); chk("rst_e2", obs(), ex(0,0,0,0,0,8'd0));
    Rst = 1'b0;
    // single request, Val0 = 3
    step(); chk("s_e0", obs(), ex(0,1,0,0,1,8'd3));
    bus.Req0 = 1'b0;
    step(); chk("s_e1", obs(), ex(0,0,0,0,1,8'd2));
    step(); chk("s_e2", obs(), ex(0,0,0,0,1,8'd1));
    step(); chk("s_e3", obs(), ex(0,0,0,0,1,8'd0));
    step(); chk("s_e4", obs(), ex(0,0,0,1,1,8'd0));
    step(); chk("s_e5", obs(), ex(0,0,0,0,0,8'd0));
    // zero-length request on requester 1
    bus.Req1 = 1'b1; bus.Val1 = 8'd0;
    step(); chk("z_e0", obs(), ex(1,0,0,0,1,8'd0));
    bus.Req1 = 1'b0;
    step(); chk("z_e1", obs(), ex(0,0,1,0,1,8'd0));
    step(); chk("z_e2", obs(), ex(0,0,0,0,0,8'd0));
    step(); chk("z_e3", obs(), ex(0,0,0,0,0,8'd0));
    // simultaneous requests from reset
    Rst = 1'b1; bus.Req0 = 1'b1; bus.Req1 = 1'b1; bus.Val0 = 8'd1; bus.Val1 = 8'd2;
    step();
    Rst = 1'b0;
    viol = 0;
    for (int k = 0; k <= 12; k++) begin
      step();
      if (bus.Gnt0) begin gk.push_back(k); gid.push_back(0); end
      if (bus.Gnt1) begin gk.push_back(k); gid.push_back(1); end
      if (int'(bus.Gnt0) + int'(bus.Gnt1) + int'(bus.Done0) + int'(bus.Done1) > 1) viol++;
    end
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    chk("rr_ngrants", gk.size(), 3);
    if (gk.size() == 3) begin
      chk("rr_id0", gid[0], 0); chk("rr_k0", gk[0], 0);
      chk("rr_id1", gid[1], 1); chk("rr_k1", gk[1], 4);
      chk("rr_id2", gid[2], 0); chk("rr_k2", gk[2], 9);
    end
    chk("rr_onehot", viol, 0);
    // reset in the middle of a countdown
    step(); chk("mr_idle", obs(), ex(0,0,0,0,0,8'd0));
    bus.Req0 = 1'b1; bus.Val0 = 8'd9;
    step(); chk("mr_e0", obs(), ex(0,1,0,0,1,8'd9));
    bus.Req0 = 1'b0;
    repeat (4) step();
    chk("mr_e4", obs(), ex(0,0,0,0,1,8'd5));
    Rst = 1'b1;
    step(); chk("mr_rst", obs(), ex(0,0,0,0,0,8'd0));
    Rst = 1'b0; bus.Req0 = 1'b1; bus.Req1 = 1'b1; bus.Val0 = 8'd2; bus.Val1 = 8'd2;
    step(); chk("mr_gnt", obs(), ex(0,1,0,0,1,8'd2));
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    repeat (4) step();
    chk("mr_busy_off", obs(), ex(0,0,0,0,0,8'd0));
    // full range, Val0 = 8'hFF
    bus.Req0 = 1'b1; bus.Val0 = 8'hFF;
    step(); chk("fr_e0", obs(), ex(0,1,0,0,1,8'hFF));
    bus.Req0 = 1'b0;
    bad = 0;
    for (int k = 1; k <= 255; k++) begin
      step();
      if (obs() !== ex(0,0,0,0,1,8'(255 - k))) bad++;
    end
    chk("fr_seq", bad, 0);
    step(); chk("fr_e256", obs(), ex(0,0,0,1,1,8'd0));
    step(); chk("fr_e257", obs(), ex(0,0,0,0,0,8'd0));
    step(); chk("fr_e258", obs(), ex(0,0,0,0,0,8'd0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
